fighter_ctrl: RTL and testbench



---
 rtl/fighter_pkg.sv | 50 +++++
 rtl/fighter_jump.sv | 65 ++++++
 rtl/fighter_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fighter_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared types and constants for the per-fighter game-logic stage.
// FIGHTER_BLOCK_EN adds the BLOCK state.
package fighter_pkg;

    localparam int SCREEN_W = 32'd640;
    localparam int SPRITE_W = 32'd120;

    localparam logic [7:0] PUNCH_DMG = 8'd8;
    localparam logic [7:0] KICK_DMG  = 8'd12;

    localparam logic [2:0] SPR_IDLE  = 3'd0;
    localparam logic [2:0] SPR_WALK  = 3'd1;
    localparam logic [2:0] SPR_PUNCH = 3'd2;
    localparam logic [2:0] SPR_KICK  = 3'd3;
    localparam logic [2:0] SPR_JUMP  = 3'd4;
    localparam logic [2:0] SPR_HIT   = 3'd5;
    localparam logic [2:0] SPR_KO    = 3'd6;
    localparam logic [2:0] SPR_BLOCK = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WALK    = 3'd1,
        ST_PUNCH   = 3'd2,
        ST_KICK    = 3'd3,
        ST_JUMP    = 3'd4,
        ST_HITSTUN = 3'd5,
        ST_KO      = 3'd6
`ifdef FIGHTER_BLOCK_EN
        ,
        ST_BLOCK   = 3'd7
`endif
    } state_t;

    function automatic logic [2:0] sprite_of(input state_t st);
        case (st)
            ST_IDLE:    sprite_of = SPR_IDLE;
            ST_WALK:    sprite_of = SPR_WALK;
            ST_PUNCH:   sprite_of = SPR_PUNCH;
            ST_KICK:    sprite_of = SPR_KICK;
            ST_JUMP:    sprite_of = SPR_JUMP;
            ST_HITSTUN: sprite_of = SPR_HIT;
            ST_KO:      sprite_of = SPR_KO;
`ifdef FIGHTER_BLOCK_EN
            ST_BLOCK:   sprite_of = SPR_BLOCK;
`endif
            default:    sprite_of = SPR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fighter_jump.sv
// Vertical motion for one fighter: owns PosY and the signed vertical velocity,
// and flags when the next step would reach or pass the ground line.
module fighter_jump #(
    parameter int GROUND_Y = 300,
    parameter int JUMP_VEL = 14
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       step_i,
    input  logic       snap_i,
    output logic [9:0] pos_y_o,
    output logic       land_o
);

    localparam logic [9:0]        GROUND_C   = 10'(GROUND_Y);
    localparam logic signed [11:0] GROUND_S  = 12'(GROUND_Y);
    localparam logic signed [5:0] JUMP_VEL_C = 6'(JUMP_VEL);

    logic [9:0]         pos_y_q, pos_y_d;
    logic signed [5:0]  vy_q, vy_d;
    logic signed [11:0] y_calc_s;

    // Positive velocity moves the sprite up, i.e. toward smaller Y.
    assign y_calc_s = $signed({2'b00, pos_y_q}) - $signed({{6{vy_q[5]}}, vy_q});
    assign land_o   = (y_calc_s >= GROUND_S);
    assign pos_y_o  = pos_y_q;

    // Next-state for height and velocity.
    always_comb begin
        pos_y_d = pos_y_q;
        vy_d    = vy_q;
        if (snap_i) begin
            pos_y_d = GROUND_C;
            vy_d    = 6'sd0;
        end else if (start_i) begin
            vy_d = JUMP_VEL_C;
        end else if (step_i) begin
            if (land_o) begin
                pos_y_d = GROUND_C;
                vy_d    = 6'sd0;
            end else if (y_calc_s < 12'sd0) begin
                pos_y_d = 10'd0;
                vy_d    = vy_q - 6'sd1;
            end else begin
                pos_y_d = y_calc_s[9:0];
                vy_d    = vy_q - 6'sd1;
            end
        end else begin
            pos_y_d = pos_y_q;
        end
    end

    // Height and velocity registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pos_y_q <= GROUND_C;
            vy_q    <= 6'sd0;
        end else begin
            pos_y_q <= pos_y_d;
            vy_q    <= vy_d;
        end
    end

endmodule

// File: rtl/fighter_ctrl.sv
// Per-fighter game logic: movement, attacks, hit handling and health.
// Define FIGHTER_BLOCK_EN to add the block input and BLOCK state.
module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter int START_X       = 120,
    parameter int GROUND_Y      = 300,
    parameter int X_MAX         = SCREEN_W - SPRITE_W,
    parameter int STEP          = 4,
    parameter int JUMP_VEL      = 14,
    parameter int ATTACK_FRAMES = 12,
    parameter int HIT_FRAMES    = 10,
    parameter int REACH         = 130,
    parameter int MAX_HEALTH    = 100
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    input  logic       punch,
    input  logic       kick,
`ifdef FIGHTER_BLOCK_EN
    input  logic       block,
`endif
    input  logic [9:0] OppX,
    input  logic       hit_in,
    input  logic [7:0] dmg_in,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [2:0] SpriteIndex,
    output logic [7:0] Health,
    output logic       atk_pulse,
    output logic [7:0] atk_dmg,
    output logic       ko
);

    localparam logic [9:0] START_X_C  = 10'(START_X);
    localparam logic [9:0] X_MAX_C    = 10'(X_MAX);
    localparam logic [9:0] STEP_C     = 10'(STEP);
    localparam logic [9:0] REACH_C    = 10'(REACH);
    localparam logic [3:0] ATK_C      = 4'(ATTACK_FRAMES);
    localparam logic [3:0] ATK_HALF_C = 4'(ATTACK_FRAMES / 2);
    localparam logic [3:0] HIT_C      = 4'(HIT_FRAMES);
    localparam logic [7:0] HEALTH_C   = 8'(MAX_HEALTH);

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic [9:0] pos_x_q, pos_x_d;
    logic [7:0] health_q, health_d;
    logic [2:0] spr_q;
    logic       atk_pulse_q, atk_pulse_d;
    logic [7:0] atk_dmg_q, atk_dmg_d;
    logic       ko_q;

    logic [9:0] step_x_s, dist_s;
    logic [7:0] dmg_eff_s, health_sub_s;
    logic       in_reach_s, hit_acc_s;
    logic       jump_start_s, jump_step_s, jump_snap_s, jump_land_s;
    logic [9:0] pos_y_s;

    // Horizontal step with saturation at both screen bounds.
    always_comb begin
        step_x_s = pos_x_q;
        if (right && !left) begin
            step_x_s = (pos_x_q >= X_MAX_C - STEP_C) ? X_MAX_C : pos_x_q + STEP_C;
        end else if (left && !right) begin
            step_x_s = (pos_x_q <= STEP_C) ? 10'd0 : pos_x_q - STEP_C;
        end else begin
            step_x_s = pos_x_q;
        end
    end

    assign dist_s     = (pos_x_q >= OppX) ? (pos_x_q - OppX) : (OppX - pos_x_q);
    assign in_reach_s = (dist_s <= REACH_C);
    assign hit_acc_s  = hit_in && (state_q != ST_KO);

`ifdef FIGHTER_BLOCK_EN
    assign dmg_eff_s = (state_q == ST_BLOCK) ? (dmg_in >> 1) : dmg_in;
`else
    assign dmg_eff_s = dmg_in;
`endif
    assign health_sub_s = (health_q > dmg_eff_s) ? (health_q - dmg_eff_s) : 8'd0;

    // Next-state and output logic; a hit overrides the frame update.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pos_x_d      = pos_x_q;
        health_d     = health_q;
        atk_pulse_d  = 1'b0;
        atk_dmg_d    = atk_dmg_q;
        jump_start_s = 1'b0;
        jump_step_s  = 1'b0;
        jump_snap_s  = 1'b0;
        if (hit_acc_s) begin
            health_d    = health_sub_s;
            jump_snap_s = (state_q == ST_JUMP);
            if (health_sub_s == 8'd0) begin
                state_d = ST_KO;
                timer_d = 4'd0;
`ifdef FIGHTER_BLOCK_EN
            end else if (state_q == ST_BLOCK) begin
                state_d = ST_BLOCK;
`endif
            end else begin
                state_d = ST_HITSTUN;
                timer_d = HIT_C;
            end
        end else if (frame_tick) begin
            case (state_q)
                ST_IDLE, ST_WALK: begin
`ifdef FIGHTER_BLOCK_EN
                    if (block) begin
                        state_d = ST_BLOCK;
                    end else
`endif
                    if (punch) begin
                        state_d = ST_PUNCH;
                        timer_d = ATK_C;
                    end else if (kick) begin
                        state_d = ST_KICK;
                        timer_d = ATK_C;
                    end else if (jump) begin
                        state_d      = ST_JUMP;
                        jump_start_s = 1'b1;
                    end else if (left ^ right) begin
                        state_d = ST_WALK;
                        pos_x_d = step_x_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PUNCH, ST_KICK: begin
                    timer_d = timer_q - 4'd1;
                    if ((timer_q - 4'd1) == ATK_HALF_C && in_reach_s) begin
                        atk_pulse_d = 1'b1;
                        atk_dmg_d   = (state_q == ST_PUNCH) ? PUNCH_DMG : KICK_DMG;
                    end else begin
                        atk_pulse_d = 1'b0;
                    end
                    if (timer_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        timer_d = 4'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_JUMP: begin
                    jump_step_s = 1'b1;
                    pos_x_d     = step_x_s;
                    if (jump_land_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_JUMP;
                    end
                end
                ST_HITSTUN: begin
                    if (timer_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        timer_d = 4'd0;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
                ST_KO: begin
                    state_d = ST_KO;
                end
`ifdef FIGHTER_BLOCK_EN
                ST_BLOCK: begin
                    state_d = block ? ST_BLOCK : ST_IDLE;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    timer_d = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, timer, position, health and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= 4'd0;
            pos_x_q     <= START_X_C;
            health_q    <= HEALTH_C;
            spr_q       <= SPR_IDLE;
            atk_pulse_q <= 1'b0;
            atk_dmg_q   <= 8'd0;
            ko_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pos_x_q     <= pos_x_d;
            health_q    <= health_d;
            spr_q       <= sprite_of(state_d);
            atk_pulse_q <= atk_pulse_d;
            atk_dmg_q   <= atk_dmg_d;
            ko_q        <= (health_d == 8'd0);
        end
    end

    fighter_jump #(
        .GROUND_Y (GROUND_Y),
        .JUMP_VEL (JUMP_VEL)
    ) u_jump (
        .clk_i   (Clk),
        .reset_i (Reset),
        .start_i (jump_start_s),
        .step_i  (jump_step_s),
        .snap_i  (jump_snap_s),
        .pos_y_o (pos_y_s),
        .land_o  (jump_land_s)
    );

    assign PosX        = pos_x_q;
    assign PosY        = pos_y_s;
    assign SpriteIndex = spr_q;
    assign Health      = health_q;
    assign atk_pulse   = atk_pulse_q;
    assign atk_dmg     = atk_dmg_q;
    assign ko          = ko_q;

endmodule

// File: tb/tb_fighter_ctrl.sv
// Scoreboard bench for fighter_ctrl: directed frames push expected snapshots
// and expected attack pulses; a negedge monitor pops and compares them.
module tb_fighter_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, frame_tick, left, right, jump, punch, kick;
    logic [9:0] OppX;
    logic       hit_in;
    logic [7:0] dmg_in;
    logic [9:0] PosX, PosY;
    logic [2:0] SpriteIndex;
    logic [7:0] Health, atk_dmg;
    logic       atk_pulse, ko;
`ifdef FIGHTER_BLOCK_EN
    logic       block;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] spr;
        logic [7:0] hp;
        logic [7:0] dmg;
        logic       k;
    } snap_t;

    typedef struct {
        int         tk;
        logic [7:0] dmg;
    } pulse_t;

    snap_t  exp_q[$];
    string  name_q[$];
    pulse_t pulse_q[$];

    int     checks = 0;
    int     errors = 0;
    int     tick_cnt = 0;
    logic   chk_req = 1'b0;

    snap_t  mon_e, mon_a;
    string  mon_nm;
    pulse_t mon_p;

    fighter_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .left        (left),
        .right       (right),
        .jump        (jump),
        .punch       (punch),
        .kick        (kick),
`ifdef FIGHTER_BLOCK_EN
        .block       (block),
`endif
        .OppX        (OppX),
        .hit_in      (hit_in),
        .dmg_in      (dmg_in),
        .PosX        (PosX),
        .PosY        (PosY),
        .SpriteIndex (SpriteIndex),
        .Health      (Health),
        .atk_pulse   (atk_pulse),
        .atk_dmg     (atk_dmg),
        .ko          (ko)
    );

    always #5 Clk = ~Clk;

    // Monitor: compares requested snapshots and every attack pulse.
    always @(negedge Clk) begin
        if (chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL snapshot: no expectation queued");
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                mon_a.x = PosX; mon_a.y = PosY; mon_a.spr = SpriteIndex;
                mon_a.hp = Health; mon_a.dmg = atk_dmg; mon_a.k = ko;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL %s: got x=%0d y=%0d spr=%0d hp=%0d dmg=%0d ko=%0d expected x=%0d y=%0d spr=%0d hp=%0d dmg=%0d ko=%0d",
                             mon_nm, mon_a.x, mon_a.y, mon_a.spr, mon_a.hp, mon_a.dmg, mon_a.k,
                             mon_e.x, mon_e.y, mon_e.spr, mon_e.hp, mon_e.dmg, mon_e.k);
                end
            end
        end
        if (atk_pulse === 1'b1) begin
            checks++;
            if (pulse_q.size() == 0) begin
                errors++;
                $display("FAIL atk_pulse: unexpected pulse at tick %0d dmg=%0d", tick_cnt, atk_dmg);
            end else begin
                mon_p = pulse_q.pop_front();
                if (mon_p.tk != tick_cnt || mon_p.dmg !== atk_dmg) begin
                    errors++;
                    $display("FAIL atk_pulse: got tick=%0d dmg=%0d expected tick=%0d dmg=%0d",
                             tick_cnt, atk_dmg, mon_p.tk, mon_p.dmg);
                end
            end
        end
    end

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge Clk);
        #1 frame_tick = 1'b0;
        tick_cnt++;
    endtask

    task automatic hit(input int d);
        hit_in = 1'b1;
        dmg_in = 8'(d);
        @(posedge Clk);
        #1 hit_in = 1'b0;
        dmg_in = 8'd0;
    endtask

    task automatic hit_tick(input int d);
        hit_in     = 1'b1;
        dmg_in     = 8'(d);
        frame_tick = 1'b1;
        @(posedge Clk);
        #1 hit_in = 1'b0;
        frame_tick = 1'b0;
        dmg_in = 8'd0;
        tick_cnt++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic expect_st(input string nm, input int x, input int y, input int s,
                             input int hp, input int dmg, input int k);
        snap_t e;
        e.x = 10'(x); e.y = 10'(y); e.spr = 3'(s);
        e.hp = 8'(hp); e.dmg = 8'(dmg); e.k = 1'(k);
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(negedge Clk);
        #1 chk_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x, y, vy, spr, k;
        logic landed;
        Reset = 1'b1; frame_tick = 1'b0; left = 1'b0; right = 1'b0; jump = 1'b0;
        punch = 1'b0; kick = 1'b0; OppX = 10'd0; hit_in = 1'b0; dmg_in = 8'd0;
`ifdef FIGHTER_BLOCK_EN
        block = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        expect_st("reset", 120, 300, 0, 100, 0, 0);

        // Walk right into the right bound, then left into zero.
        right = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            expect_st("walk_right", (120 + 4 * i > 520) ? 520 : 120 + 4 * i, 300, 1, 100, 0, 0);
        end
        right = 1'b0; left = 1'b1;
        for (int i = 1; i <= 140; i++) begin
            tick();
            expect_st("walk_left", (520 - 4 * i < 0) ? 0 : 520 - 4 * i, 300, 1, 100, 0, 0);
        end
        left = 1'b0;
        tick();
        expect_st("idle_at_zero", 0, 300, 0, 100, 0, 0);

        // Punch in reach; right held to show inputs are ignored.
        OppX = 10'd100; punch = 1'b1; right = 1'b1;
        tick();
        punch = 1'b0;
        pulse_q.push_back('{tick_cnt + 6, 8'd8});
        expect_st("punch_start", 0, 300, 2, 100, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            expect_st("punch_near", 0, 300, (i < 12) ? 2 : 0, 100, (i >= 6) ? 8 : 0, 0);
        end
        right = 1'b0;

        // Punch out of reach: no pulse, dmg holds.
        OppX = 10'd200; punch = 1'b1;
        tick();
        punch = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            expect_st("punch_far", 0, 300, (i < 12) ? 2 : 0, 100, 8, 0);
        end

        // Kick at exactly the reach limit.
        OppX = 10'd130; kick = 1'b1;
        tick();
        kick = 1'b0;
        pulse_q.push_back('{tick_cnt + 6, 8'd12});
        for (int i = 1; i <= 12; i++) begin
            tick();
            expect_st("kick_edge", 0, 300, (i < 12) ? 3 : 0, 100, (i >= 6) ? 12 : 8, 0);
        end

        // Jump with air control to the right.
        right = 1'b1; jump = 1'b1;
        tick();
        jump = 1'b0;
        expect_st("jump_start", 0, 300, 4, 100, 12, 0);
        y = 300; vy = 14; k = 0; landed = 1'b0;
        while (!landed && k < 40) begin
            k++;
            tick();
            y = y - vy;
            vy = vy - 1;
            if (y >= 300) begin
                y = 300;
                landed = 1'b1;
            end
            spr = landed ? 0 : 4;
            if (k == 1) expect_st("jump_y1", 4, 286, 4, 100, 12, 0);
            else if (k == 2) expect_st("jump_y2", 8, 273, 4, 100, 12, 0);
            else expect_st("jump_arc", 4 * k, y, spr, 100, 12, 0);
        end
        right = 1'b0;

        // Reset mid-jump.
        jump = 1'b1;
        tick();
        jump = 1'b0;
        repeat (5) tick();
        do_reset();
        expect_st("reset_mid_jump", 120, 300, 0, 100, 0, 0);

        // Airborne hit snaps to ground; repeated hit reloads hit-stun.
        jump = 1'b1;
        tick();
        jump = 1'b0;
        repeat (3) tick();
        expect_st("air_y3", 120, 261, 4, 100, 0, 0);
        hit(10);
        expect_st("air_hit", 120, 300, 5, 90, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            expect_st("stun", 120, 300, 5, 90, 0, 0);
        end
        hit(10);
        expect_st("stun_reload", 120, 300, 5, 80, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            expect_st("stun_end", 120, 300, (i < 10) ? 5 : 0, 80, 0, 0);
        end

        // Hit on the frame where the kick would connect.
        OppX = 10'd200; kick = 1'b1;
        tick();
        kick = 1'b0;
        repeat (5) tick();
        expect_st("kick_t7", 120, 300, 3, 80, 0, 0);
        right = 1'b1;
        hit_tick(20);
        right = 1'b0;
        expect_st("kick_hit", 120, 300, 5, 60, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            expect_st("kick_stun", 120, 300, (i < 10) ? 5 : 0, 60, 0, 0);
        end

        // Hit stream to KO, then KO is absorbing.
        do_reset();
        expect_st("reset2", 120, 300, 0, 100, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            hit(30);
            expect_st("hit_stream", 120, 300, (i < 4) ? 5 : 6,
                      (100 - 30 * i < 0) ? 0 : 100 - 30 * i, 0, (i == 4) ? 1 : 0);
        end
        hit(30);
        expect_st("ko_hit", 120, 300, 6, 0, 0, 1);
        right = 1'b1; punch = 1'b1;
        tick();
        right = 1'b0; punch = 1'b0;
        expect_st("ko_tick", 120, 300, 6, 0, 0, 1);

`ifdef FIGHTER_BLOCK_EN
        do_reset();
        block = 1'b1;
        tick();
        expect_st("block_enter", 120, 300, 7, 100, 0, 0);
        hit(13);
        expect_st("block_hit", 120, 300, 7, 94, 0, 0);
        tick();
        expect_st("block_hold", 120, 300, 7, 94, 0, 0);
        block = 1'b0;
        tick();
        expect_st("block_release", 120, 300, 0, 94, 0, 0);
`endif

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        #1;
        checks++;
        if (pulse_q.size() != 0) begin
            errors++;
            $display("FAIL pulse_missing: got %0d outstanding pulses expected 0", pulse_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
